pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/mips_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline hazard controller slice.
package mips_pkg;

   // Register-index width of the five-stage MIPS-style core.
   localparam int REG_WIDTH = 5;

   // Edges between HALT leaving ID and HALT retiring from WB.
   localparam logic [1:0] DRAIN_LEN = 2'd3;

   // Hazard controller sequencing: normal issue, draining after HALT, stopped.
   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_HALTED = 2'b10
   } hz_state_e;

   // EX operand source select: register file, EX/MEM latch, MEM/WB latch.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding select for one EX operand: picks the youngest in-flight writer
// of the operand's source register, never forwarding register 0.
module fwd_select
   import mips_pkg::*;
#(
   parameter int reg_width = REG_WIDTH
) (
   input  logic [reg_width-1:0] src,
   input  logic                 mem_valid,
   input  logic                 mem_regwrite,
   input  logic [reg_width-1:0] mem_rd,
   input  logic                 wb_valid,
   input  logic                 wb_regwrite,
   input  logic [reg_width-1:0] wb_rd,
   output fwd_sel_e             sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == src);
   assign wb_hit  = wb_valid  & wb_regwrite  & (wb_rd  != '0) & (wb_rd  == src);

   // MEM holds the younger result, so it takes priority over WB.
   always_comb begin
      sel = FWD_REG;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, operand
// forwarding selects, HALT drain sequencing and saturating event counters.
module pipe_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int reg_width = REG_WIDTH,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic                 id_is_halt,
   input  logic [reg_width-1:0] id_rs1,
   input  logic [reg_width-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_valid,
   input  logic                 ex_regwrite,
   input  logic                 ex_is_load,
   input  logic [reg_width-1:0] ex_rd,
   input  logic [reg_width-1:0] ex_rs1,
   input  logic [reg_width-1:0] ex_rs2,
   input  logic                 mem_valid,
   input  logic                 mem_regwrite,
   input  logic [reg_width-1:0] mem_rd,
   input  logic                 wb_valid,
   input  logic                 wb_regwrite,
   input  logic [reg_width-1:0] wb_rd,
   input  logic                 ex_redirect,
   output logic                 stall_if_id,
   output logic                 bubble_ex,
   output logic                 flush,
   output logic [1:0]           fwd_a,
   output logic [1:0]           fwd_b,
   output logic                 halted,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_e  state;
   logic [1:0] drain_cnt;
   logic       load_use;
   logic       run_stall;
   logic       run_flush;
   fwd_sel_e   fwd_a_sel;
   fwd_sel_e   fwd_b_sel;

   // A load in EX whose nonzero destination feeds a source the ID instruction reads.
   assign load_use = ex_valid & ex_is_load & ex_regwrite & (ex_rd != '0) & id_valid &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // Events that count only while issuing normally; a redirect kills the stalled pair.
   assign run_flush = (state == ST_RUN) & ex_redirect;
   assign run_stall = (state == ST_RUN) & load_use & ~ex_redirect;

   fwd_select #(.reg_width(reg_width)) u_fwd_a (
      .src          (ex_rs1),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_valid     (wb_valid),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .sel          (fwd_a_sel)
   );

   fwd_select #(.reg_width(reg_width)) u_fwd_b (
      .src          (ex_rs2),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_valid     (wb_valid),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .sel          (fwd_b_sel)
   );

   // Forwarding selects fall back to the register file while reset is held.
   assign fwd_a = reset ? FWD_REG : fwd_a_sel;
   assign fwd_b = reset ? FWD_REG : fwd_b_sel;

   // Same-cycle pipeline control: redirect beats load-use, drain/halt freezes the front end.
   always_comb begin
      stall_if_id = 1'b0;
      bubble_ex   = 1'b0;
      flush       = 1'b0;
      if (!reset) begin
         case (state)
            ST_RUN: begin
               if (ex_redirect) begin
                  flush = 1'b1;
               end else if (load_use) begin
                  stall_if_id = 1'b1;
                  bubble_ex   = 1'b1;
               end
            end
            ST_DRAIN, ST_HALTED: begin
               stall_if_id = 1'b1;
               bubble_ex   = 1'b1;
            end
            default: begin
               stall_if_id = 1'b0;
            end
         endcase
      end
   end

   // HALT sequencing: a HALT that issues from ID drains three stages, then parks until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= 2'd0;
         halted    <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (id_valid & id_is_halt & ~ex_redirect & ~load_use) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LEN;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt <= 2'd1) begin
                  state     <= ST_HALTED;
                  drain_cnt <= 2'd0;
                  halted    <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 2'd1;
               end
            end
            ST_HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               state     <= ST_RUN;
               drain_cnt <= 2'd0;
               halted    <= 1'b0;
            end
         endcase
      end
   end

   // Saturating performance counters for load-use stall cycles and redirect flushes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (run_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (run_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule
